// File: rtl/pattern_detect_ctrl_pkg.sv
// Shared types and constants for the programmable serial pattern-detect controller.
package pattern_detect_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DONE
  } state_e;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pattern_detect_ctrl_if.sv
// Host/config and serial-stream signal bundle for pattern_detect_ctrl.
interface pattern_detect_ctrl_if
  import pattern_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               x;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x,
    input  cfg_ready, z, match_cnt, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x,
    output cfg_ready, z, match_cnt, busy, done, err
  );

endinterface

// File: rtl/pattern_detect_ctrl_window.sv
// Serial shift window with fill tracking and a length-masked compare against the pattern.
module pattern_window
  import pattern_detect_pkg::*;
#(
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
  localparam int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_shift,
  input  logic               i_clear,
  input  logic               i_clear_on_hit,
  input  logic               i_x,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [MAX_LEN-1:0] i_pattern,
  output logic               o_hit
);

  logic [MAX_LEN-1:0] r_win;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_win_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_next;

  // The hit looks at the window as it will be after this edge, so z can be registered on it.
  always_comb begin
    w_win_next  = {r_win[MAX_LEN-2:0], i_x};
    w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    w_mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(i_len));
    end
    o_hit = i_shift && (w_fill_next >= i_len) &&
            (((w_win_next ^ i_pattern) & w_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_win  <= w_win_next;
      r_fill <= (o_hit && i_clear_on_hit) ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Pattern-detect controller: config handshake, IDLE/ARMED/RUN/DONE FSM, match counter and z pulse.
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  pattern_detect_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  state_e             r_state;
  state_e             w_state_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_z;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_cfg_ok;
  logic               w_cfg_take;
  logic               w_cfg_bad;
  logic               w_cfg_drop;
  logic               w_run_clear;
  logic               w_shift;
  logic               w_hit;
  logic               w_count;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Kept outside the FSM block so the window's hit does not loop back through it.
  assign w_shift = (r_state == ST_RUN) && !bus.abort;

  pattern_window #(
    .MAX_LEN(MAX_LEN)
  ) u_window (
    .clk           (clk),
    .rst           (rst),
    .i_shift       (w_shift),
    .i_clear       (w_run_clear),
    .i_clear_on_hit(!r_overlap),
    .i_x           (bus.x),
    .i_len         (r_len),
    .i_pattern     (r_pattern),
    .o_hit         (w_hit)
  );

  always_comb begin
    w_cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    w_state_next = r_state;
    w_cfg_take   = 1'b0;
    w_cfg_bad    = 1'b0;
    w_cfg_drop   = 1'b0;
    w_run_clear  = 1'b0;
    w_count      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          if (w_cfg_ok) begin
            w_cfg_take   = 1'b1;
            w_state_next = ST_ARMED;
          end else begin
            w_cfg_bad = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (bus.abort) begin
          w_cfg_drop   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (bus.start) begin
          w_run_clear  = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_cfg_drop   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_hit) begin
          w_count = 1'b1;
          if ((r_target != '0) && (w_cnt_inc == r_target)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          w_cfg_drop   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (bus.cfg_valid) begin
          if (w_cfg_ok) begin
            w_cfg_take   = 1'b1;
            w_state_next = ST_ARMED;
          end else begin
            w_cfg_bad = 1'b1;
          end
        end else if (bus.start) begin
          w_run_clear  = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);
      r_z     <= w_count;
      r_err   <= w_cfg_bad;
      if (w_run_clear) begin
        r_cnt <= '0;
      end else if (w_count) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
    end else if (w_cfg_take) begin
      r_pattern <= bus.cfg_pattern;
      r_len     <= bus.cfg_len;
      r_overlap <= bus.cfg_overlap;
      r_target  <= bus.cfg_target;
    end else if (w_cfg_drop) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
    end
  end

  assign bus.cfg_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign bus.z         = r_z;
  assign bus.match_cnt = r_cnt;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed and randomized checks of pattern_detect_ctrl against a bit-history reference model.
module tb_pattern_detect_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pattern_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  pattern_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 armed, 2 run, 3 done; hist holds bits eligible for a match.
  int         m_st  = 0;
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  bit         m_ovl = 1'b0;
  int         m_tgt = 0;
  int         m_cnt = 0;
  bit         m_z   = 1'b0;
  bit         m_err = 1'b0;
  bit         hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tail_matches();
    int base;
    base = hist.size() - m_len;
    for (int i = 0; i < m_len; i++) begin
      if (hist[base + i] != m_pat[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_cfg();
    int len;
    len = int'(bus.cfg_len);
    if (len >= 1 && len <= int'(MAX_LEN)) begin
      m_pat = bus.cfg_pattern;
      m_len = len;
      m_ovl = bus.cfg_overlap;
      m_tgt = int'(bus.cfg_target);
      m_st  = 1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_go();
    m_cnt = 0;
    hist.delete();
    m_st = 2;
  endtask

  task automatic model_step();
    m_z   = 1'b0;
    m_err = 1'b0;
    case (m_st)
      0: if (bus.cfg_valid) model_cfg();
      1: begin
        if (bus.abort) m_st = 0;
        else if (bus.start) model_go();
      end
      2: begin
        if (bus.abort) begin
          m_st = 0;
        end else begin
          hist.push_back(bus.x);
          if (hist.size() > 16) void'(hist.pop_front());
          if (hist.size() >= m_len && tail_matches()) begin
            m_z = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) hist.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_st = 3;
          end
        end
      end
      default: begin
        if (bus.abort) m_st = 0;
        else if (bus.cfg_valid) model_cfg();
        else if (bus.start) model_go();
      end
    endcase
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_z"},     32'(bus.z),         32'(m_z));
    check({tag, "_cnt"},   32'(bus.match_cnt), 32'(m_cnt));
    check({tag, "_busy"},  32'(bus.busy),      32'(m_st == 2));
    check({tag, "_done"},  32'(bus.done),      32'(m_st == 3));
    check({tag, "_err"},   32'(bus.err),       32'(m_err));
    check({tag, "_ready"}, 32'(bus.cfg_ready), 32'(m_st == 0 || m_st == 3));
  endtask

  task automatic idle_in();
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_target  = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.x           = 1'b0;
  endtask

  task automatic do_cfg(input int len, input logic [7:0] pat, input bit ovl, input int tgt);
    idle_in();
    bus.cfg_valid   = 1'b1;
    bus.cfg_len     = 4'(len);
    bus.cfg_pattern = pat;
    bus.cfg_overlap = ovl;
    bus.cfg_target  = 8'(tgt);
    step("cfg");
  endtask

  task automatic do_start();
    idle_in();
    bus.start = 1'b1;
    step("start");
  endtask

  task automatic do_abort();
    idle_in();
    bus.abort = 1'b1;
    step("abort");
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      idle_in();
      bus.x = bits[i];
      step("bit");
    end
  endtask

  initial begin
    idle_in();
    #1 rst = 1'b0;
    #1;
    check("rst_z",     32'(bus.z),         32'd0);
    check("rst_cnt",   32'(bus.match_cnt), 32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    check("rst_ready", 32'(bus.cfg_ready), 32'd1);
    #6 rst = 1'b1;

    // Overlapping 110110 over 110110110
    do_cfg(6, 8'b0011_0110, 1'b1, 0);
    do_start();
    feed(16'b1_1011_0110, 9);
    check("t1_cnt", 32'(bus.match_cnt), 32'd2);
    do_abort();

    // Non-overlapping: only one match
    do_cfg(6, 8'b0011_0110, 1'b0, 0);
    do_start();
    feed(16'b1_1011_0110, 9);
    check("t2_cnt", 32'(bus.match_cnt), 32'd1);
    do_abort();

    // Target of 2 ends the run
    do_cfg(6, 8'b0011_0110, 1'b1, 2);
    do_start();
    feed(16'b1_1011_0110, 9);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_busy", 32'(bus.busy), 32'd0);
    feed(16'b1011_0110_1101_1011, 16);
    do_start();
    check("t3_restart_cnt",  32'(bus.match_cnt), 32'd0);
    check("t3_restart_busy", 32'(bus.busy),      32'd1);
    do_abort();

    // Illegal lengths in IDLE
    do_cfg(0, 8'hff, 1'b0, 0);
    check("t4_err0", 32'(bus.err), 32'd1);
    idle_in();
    step("t4_gap");
    do_cfg(int'(MAX_LEN) + 1, 8'hff, 1'b0, 0);
    check("t4_err9", 32'(bus.err), 32'd1);
    do_start();
    check("t4_busy", 32'(bus.busy), 32'd0);

    // Abort on the final bit suppresses the match
    do_cfg(6, 8'b0011_0110, 1'b1, 0);
    do_start();
    feed(16'b11011, 5);
    idle_in();
    bus.x     = 1'b0;
    bus.abort = 1'b1;
    step("t5_abort");
    check("t5_z",     32'(bus.z),         32'd0);
    check("t5_cnt",   32'(bus.match_cnt), 32'd0);
    check("t5_ready", 32'(bus.cfg_ready), 32'd1);

    // Full-length pattern, non-overlapping, two copies
    do_cfg(int'(MAX_LEN), 8'b1010_0111, 1'b0, 0);
    do_start();
    feed(16'b1010_0111_1010_0111, 16);
    check("t7_cnt", 32'(bus.match_cnt), 32'd2);
    do_abort();

    // Counter saturation
    do_cfg(1, 8'b1, 1'b1, 0);
    do_start();
    for (int i = 0; i < 300; i++) begin
      idle_in();
      bus.x = 1'b1;
      step("sat");
    end
    check("t8_sat", 32'(bus.match_cnt), 32'd255);
    do_abort();

    // Asynchronous reset mid-run, right as z is high
    do_cfg(6, 8'b0011_0110, 1'b1, 0);
    do_start();
    feed(16'b110110, 6);
    check("t6_zpre", 32'(bus.z), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("t6_z",    32'(bus.z),         32'd0);
    check("t6_busy", 32'(bus.busy),      32'd0);
    check("t6_done", 32'(bus.done),      32'd0);
    check("t6_cnt",  32'(bus.match_cnt), 32'd0);
    m_st  = 0;
    m_cnt = 0;
    m_len = 0;
    hist.delete();
    #2 rst = 1'b1;
    do_start();
    check("t6_nostart", 32'(bus.busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle_in();
      bus.cfg_valid   = ($urandom_range(0, 99) < 6);
      bus.cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(1, 4));
      bus.cfg_pattern = 8'($urandom);
      bus.cfg_overlap = 1'($urandom_range(0, 1));
      bus.cfg_target  = 8'($urandom_range(0, 3));
      bus.start       = ($urandom_range(0, 99) < 8);
      bus.abort       = ($urandom_range(0, 99) < 2);
      bus.x           = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
